shift_sequencer: RTL and testbench

Multi-cycle shift/rotate controller for the ALU. Accepts one operation (ROL, ROR, SHL, SHR, SHRA) with a 32-bit operand and shift amount, and sequences a narrow step shifter over several cycles, STEP bit positions per cycle, instead of using a full barrel network. Sits beside the combinational ALU ops; the control unit raises `start` and waits for `done` before latching `C` into register Z.

---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_step.sv | 35 +++
 rtl/shift_sequencer.sv | 133 +++++++++++++
 tb/tb_shift_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate sequencer:
// operation codes, sequencer states and the shift-amount decode.
package shift_pkg;

    localparam logic [2:0] OP_ROL  = 3'd0;
    localparam logic [2:0] OP_ROR  = 3'd1;
    localparam logic [2:0] OP_SHL  = 3'd2;
    localparam logic [2:0] OP_SHR  = 3'd3;
    localparam logic [2:0] OP_SHRA = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Negative amounts and reserved op codes collapse to a zero-length shift.
    function automatic logic [4:0] shift_amount(input logic [2:0] op, input logic [31:0] b);
        logic unused_hi;
        unused_hi = ^b[30:5];
        if (b[31] || (op > OP_SHRA)) begin
            shift_amount = 5'd0;
        end else begin
            shift_amount = b[4:0];
        end
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational step shifter: moves a WIDTH-bit value by k (0..STEP)
// positions for one of the rotate/shift operations.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int KW    = 1
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [KW-1:0]    i_k,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_result
);

    logic [31:0] w_k_ext;
    logic [31:0] w_k_comp;

    assign w_k_ext  = 32'(i_k);
    // A complementary shift of WIDTH yields zero, so k=0 rotates cleanly.
    assign w_k_comp = 32'(WIDTH) - w_k_ext;

    // Select the shifted value for the requested operation.
    always_comb begin
        o_result = i_value;
        case (i_op)
            OP_ROL:  o_result = (i_value << w_k_ext) | (i_value >> w_k_comp);
            OP_ROR:  o_result = (i_value >> w_k_ext) | (i_value << w_k_comp);
            OP_SHL:  o_result = i_value << w_k_ext;
            OP_SHR:  o_result = i_value >> w_k_ext;
            OP_SHRA: o_result = $signed(i_value) >>> w_k_ext;
            default: o_result = i_value;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller stepping STEP bits per cycle.
// Optional abort input enabled by defining SHIFT_SEQ_ABORT_EN.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C
);

    localparam int KW = $clog2(STEP + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [4:0]       r_rem;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_c;
    logic             r_busy;
    logic             r_done;

    state_t           w_next;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [4:0]       w_rem_nxt;
    logic [2:0]       w_op_nxt;
    logic [WIDTH-1:0] w_c_nxt;
    logic [4:0]       w_n;
    logic [KW-1:0]    w_k;
    logic             w_last;
    logic             w_abort;
    logic [WIDTH-1:0] w_step;

    assign w_n    = shift_amount(op, B);
    assign w_k    = (r_rem < 5'(STEP)) ? r_rem[KW-1:0] : KW'(STEP);
    assign w_last = (r_rem == 5'(w_k));

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    shift_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .i_value  (r_acc),
        .i_k      (w_k),
        .i_op     (r_op),
        .o_result (w_step)
    );

    // Next-state and datapath update decisions.
    always_comb begin
        w_next    = r_state;
        w_acc_nxt = r_acc;
        w_rem_nxt = r_rem;
        w_op_nxt  = r_op;
        w_c_nxt   = r_c;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_acc_nxt = A;
                    w_rem_nxt = w_n;
                    w_op_nxt  = op;
                    if (w_n != 5'd0) begin
                        w_next = RUN;
                    end else begin
                        w_next  = DONE;
                        w_c_nxt = A;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                // Abort wins over a completion falling in the same cycle.
                if (w_abort) begin
                    w_next = IDLE;
                end else begin
                    w_acc_nxt = w_step;
                    w_rem_nxt = r_rem - 5'(w_k);
                    if (w_last) begin
                        w_next  = DONE;
                        w_c_nxt = w_step;
                    end else begin
                        w_next = RUN;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_rem   <= 5'd0;
            r_op    <= 3'd0;
            r_c     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_acc   <= w_acc_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
            r_c     <= w_c_nxt;
            r_busy  <= (w_next == RUN);
            r_done  <= (w_next == DONE);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign C    = r_c;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: two sequencers (STEP=1 and STEP=4) share random
// stimulus and are checked every cycle against a transaction-level model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        clear;
    logic        start_i;
    logic        abort_i;
    logic        abort_on;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [1:0]  busy_v;
    logic [1:0]  done_v;
    logic [31:0] c_v [2];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_on = abort_i;
`else
    assign abort_on = 1'b0;
`endif

    shift_sequencer #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clock (clk), .clear (clear), .start (start_i), .op (op_i), .A (a_i), .B (b_i),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort (abort_i),
`endif
        .busy (busy_v[0]), .done (done_v[0]), .C (c_v[0])
    );

    shift_sequencer #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clock (clk), .clear (clear), .start (start_i), .op (op_i), .A (a_i), .B (b_i),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort (abort_i),
`endif
        .busy (busy_v[1]), .done (done_v[1]), .C (c_v[1])
    );

    function automatic int step_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int ref_amount(input logic [2:0] o, input logic [31:0] b);
        if (b[31] || (o > 3'd4)) return 0;
        return int'(b[4:0]);
    endfunction

    // Whole-amount result, defined bit by bit from source index.
    function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] a, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            case (o)
                3'd0:    r[i] = a[(i - n + 32) % 32];
                3'd1:    r[i] = a[(i + n) % 32];
                3'd2:    r[i] = (i >= n) ? a[(i - n) % 32] : 1'b0;
                3'd3:    r[i] = (i + n < 32) ? a[(i + n) % 32] : 1'b0;
                3'd4:    r[i] = (i + n < 32) ? a[(i + n) % 32] : a[31];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    bit          m_busy [2];
    bit          m_done [2];
    logic [31:0] m_c    [2];
    logic [31:0] m_pend [2];
    int          m_cnt  [2];

    // Transaction model: remaining cycles until done, result precomputed.
    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d] <= 1'b0;
                m_done[d] <= 1'b0;
                m_c[d]    <= 32'h0;
                m_cnt[d]  <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_busy[d]) begin
                    if (abort_on) begin
                        m_busy[d] <= 1'b0;
                        m_done[d] <= 1'b0;
                    end else if (m_cnt[d] == 1) begin
                        m_busy[d] <= 1'b0;
                        m_done[d] <= 1'b1;
                        m_c[d]    <= m_pend[d];
                    end else begin
                        m_cnt[d]  <= m_cnt[d] - 1;
                        m_done[d] <= 1'b0;
                    end
                end else if (start_i) begin
                    if (ref_amount(op_i, b_i) == 0) begin
                        m_done[d] <= 1'b1;
                        m_c[d]    <= a_i;
                    end else begin
                        m_busy[d] <= 1'b1;
                        m_done[d] <= 1'b0;
                        m_cnt[d]  <= (ref_amount(op_i, b_i) + step_of(d) - 1) / step_of(d);
                        m_pend[d] <= ref_shift(op_i, a_i, ref_amount(op_i, b_i));
                    end
                end else begin
                    m_done[d] <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy1, output int busy4, output int done1, output int done4);
        busy1 = 0; busy4 = 0; done1 = -1; done4 = -1;
        @(posedge clk); #1;
        op_i = o; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (busy_v[0]) busy1++;
            if (busy_v[1]) busy4++;
            if (done_v[0] && done1 < 0) done1 = j;
            if (done_v[1] && done4 < 0) done4 = j;
            if (done1 >= 0 && done4 >= 0) break;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_v != 2'b00 || done_v != 2'b00) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n < 60), 32'h1);
    endtask

    initial begin
        int b1, b4, d1, d4, seen, ndone;
        clear = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        op_i = 3'd0; a_i = 32'h0; b_i = 32'h0;

        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    for (int d = 0; d < 2; d++) begin
                        vectors++;
                        if (busy_v[d] !== m_busy[d] || done_v[d] !== m_done[d] || c_v[d] !== m_c[d]) begin
                            miscompares++;
                            $display("FAIL cycle dut%0d t=%0t: busy=%b done=%b C=%h expected busy=%b done=%b C=%h",
                                     d, $time, busy_v[d], done_v[d], c_v[d], m_busy[d], m_done[d], m_c[d]);
                        end
                    end
                end
            end
        join_none

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_done", 32'(done_v), 32'h0);
        check("rst_C1", c_v[0], 32'h0);
        clear = 1'b1;

        check("ref_rol4", ref_shift(3'd0, 32'h80000001, 4), 32'h00000018);
        check("ref_ror1", ref_shift(3'd1, 32'h00000003, 1), 32'h80000001);
        check("ref_shra8", ref_shift(3'd4, 32'hF0000000, 8), 32'hFFF00000);

        run_op(3'd0, 32'h80000001, 32'd4, b1, b4, d1, d4);
        check("t1_busy1", 32'(b1), 32'd4);
        check("t1_done1", 32'(d1), 32'd5);
        check("t1_C1", c_v[0], 32'h00000018);
        check("t1_busy4", 32'(b4), 32'd1);
        check("t1_C4", c_v[1], 32'h00000018);

        run_op(3'd4, 32'hF0000000, 32'd8, b1, b4, d1, d4);
        check("t2_done4", 32'(d4), 32'd3);
        check("t2_busy4", 32'(b4), 32'd2);
        check("t2_C4", c_v[1], 32'hFFF00000);
        check("t2_done1", 32'(d1), 32'd9);
        run_op(3'd3, 32'hF0000000, 32'd8, b1, b4, d1, d4);
        check("t2_shr_C4", c_v[1], 32'h00F00000);
        check("t2_shr_C1", c_v[0], 32'h00F00000);

        run_op(3'd1, 32'h12345678, 32'h80000005, b1, b4, d1, d4);
        check("t3_busy1", 32'(b1), 32'd0);
        check("t3_done1", 32'(d1), 32'd1);
        check("t3_C1", c_v[0], 32'h12345678);

        // ROL by 31 with an ignored start mid-run, then back-to-back start.
        @(posedge clk); #1;
        op_i = 3'd0; a_i = 32'h00000003; b_i = 32'd31; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        seen = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (j == 10) begin
                start_i = 1'b1; op_i = 3'd2; a_i = $urandom; b_i = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            if (done_v[0]) begin
                seen = j;
                break;
            end
        end
        check("t4_done1", 32'(seen), 32'd32);
        check("t4_C1", c_v[0], 32'h80000001);
        start_i = 1'b1; op_i = 3'd1; a_i = $urandom; b_i = 32'd6;
        @(negedge clk);
        start_i = 1'b0;
        check("t4_b2b_busy", 32'(busy_v[0]), 32'h1);
        check("t4_b2b_done", 32'(done_v[0]), 32'h0);
        wait_idle();

        // Reset in the middle of a 20-position shift.
        @(posedge clk); #1;
        op_i = 3'd2; a_i = $urandom; b_i = 32'd20; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        check("t5_busy", 32'(busy_v), 32'h0);
        check("t5_done", 32'(done_v), 32'h0);
        check("t5_C1", c_v[0], 32'h0);
        check("t5_C4", c_v[1], 32'h0);
        @(negedge clk);
        clear = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_v != 2'b00) ndone++;
        end
        check("t5_no_done", 32'(ndone), 32'd0);

`ifdef SHIFT_SEQ_ABORT_EN
        run_op(3'd0, 32'hAAAA5555, 32'd0, b1, b4, d1, d4);
        @(posedge clk); #1;
        op_i = 3'd2; a_i = 32'h1; b_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("t6_busy", 32'(busy_v), 32'h0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v != 2'b00) ndone++;
        end
        check("t6_no_done", 32'(ndone), 32'd0);
        check("t6_C1", c_v[0], 32'hAAAA5555);
        check("t6_C4", c_v[1], 32'hAAAA5555);
`endif

        // Random traffic: dense starts, all op codes, edge-case amounts.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            @(posedge clk); #1;
            clear   = ($urandom_range(0, 399) != 0);
            start_i = ($urandom_range(0, 3) == 0);
            op_i    = 3'($urandom_range(0, 7));
            a_i     = $urandom;
            r       = $urandom_range(0, 9);
            if (r == 0)      b_i = 32'h80000000 | $urandom;
            else if (r == 1) b_i = 32'd0;
            else if (r == 2) b_i = $urandom & 32'h7FFFFFFF;
            else             b_i = 32'($urandom_range(0, 31));
            abort_i = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #1;
        clear = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
